mem_arbiter: RTL

- Two-requester arbiter that shares the single-port synchronous SoC memory between the CPU (port 0) and a program-loader/debug master (port 1).
- Sits between the requesters and the memory inside soc. Serialises accesses, drives the memory strobe and write mask, and returns read data to the winning requester after the memory's fixed read latency.
- One transaction in flight at a time. No pipelining.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_pick2.sv | 27 ++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// FSM encoding, requester port indices and the read write-mask code.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam logic [3:0] WMASK_READ = 4'b0000;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way request picker (round-robin or fixed priority).
// Ports: valid_i[1:0] requests, last_gnt_i previous winner,
//        fixed_prio_i port 0 wins ties, gnt_any_o, gnt_idx_o winner.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_gnt_i,
  input  logic       fixed_prio_i,
  output logic       gnt_any_o,
  output logic       gnt_idx_o
);

  always_comb begin
    gnt_any_o = |valid_i;
    gnt_idx_o = PORT_CPU;
    unique case (1'b1)
      (valid_i == 2'b11):
        gnt_idx_o = fixed_prio_i ? PORT_CPU : ~last_gnt_i;
      (valid_i == 2'b10):
        gnt_idx_o = PORT_LDR;
      default:
        gnt_idx_o = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU (port 0) and loader (port 1) accesses onto one
// single-port synchronous memory, one transaction in flight.
// Ports: clk, rst (async, active-high);
//   pN_valid/addr/wdata/wmask in, pN_ready/rsp_valid/rdata out;
//   mem_en/addr/wdata/wmask out, mem_rdata in.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIXED_PRIO   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W/8-1:0] p0_wmask,
  output logic              p0_ready,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_valid,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [DATA_W/8-1:0] p1_wmask,
  output logic              p1_ready,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int MW = DATA_W / 8;
  localparam int CW = 2;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(READ_LATENCY - 1);

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]        req;
  logic              gnt_any;
  logic              gnt_idx;
  logic              accept;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [MW-1:0]     win_wmask;

  // Requests are masked during reset so every
  // combinational output is 0 while rst is high.
  assign req = {p1_valid, p0_valid} & {2{~rst}};

  rr_pick2 u_pick (
    .valid_i      (req),
    .last_gnt_i   (last_q),
    .fixed_prio_i (FIXED_PRIO != 0),
    .gnt_any_o    (gnt_any),
    .gnt_idx_o    (gnt_idx)
  );

  assign accept = (state_q == ST_IDLE) && gnt_any;

  assign win_addr  = gnt_idx ? p1_addr  : p0_addr;
  assign win_wdata = gnt_idx ? p1_wdata : p0_wdata;
  assign win_wmask = gnt_idx ? p1_wmask : p0_wmask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= PORT_CPU;
      last_q  <= PORT_LDR;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          gnt_d  = gnt_idx;
          last_d = gnt_idx;
          rd_d   = (win_wmask == MW'(WMASK_READ));
          cnt_d  = CNT_INIT;
          state_d = (READ_LATENCY > 1) ? ST_WAIT
                                       : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    p0_ready     = 1'b0;
    p1_ready     = 1'b0;
    p0_rsp_valid = 1'b0;
    p1_rsp_valid = 1'b0;
    p0_rdata     = '0;
    p1_rdata     = '0;
    mem_en       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wmask    = '0;
    if (accept) begin
      mem_en    = 1'b1;
      mem_addr  = win_addr;
      mem_wdata = win_wdata;
      mem_wmask = win_wmask;
      p0_ready  = (gnt_idx == PORT_CPU);
      p1_ready  = (gnt_idx == PORT_LDR);
    end
    if (state_q == ST_RESP) begin
      if (gnt_q == PORT_LDR) begin
        p1_rsp_valid = 1'b1;
        p1_rdata     = rd_q ? mem_rdata : '0;
      end else begin
        p0_rsp_valid = 1'b1;
        p0_rdata     = rd_q ? mem_rdata : '0;
      end
    end
  end

endmodule
